instr_fetch_decode: RTL and testbench

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

---
 rtl/instr_fetch_decode_if.sv | 32 +++
 rtl/instr_fetch_decode.sv | 131 +++++++++++++
 tb/tb_instr_fetch_decode.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_decode_if.sv
// Bus between the fetch/decode block (master) and its ROM plus the issue consumer (slave).
// Issue handshake: the master raises issue_valid with op/rd/rs/imm/we/alu_sel and holds them
// stable until it samples issue_ready=1 on a rising clk edge; that edge is the only transfer.
interface instr_fetch_decode_if;
  logic [2:0]  rom_addr;
  logic        rom_en;
  logic [24:0] rom_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [15:0] imm;
  logic        we;
  logic [1:0]  alu_sel;

  modport master (
    output rom_addr, rom_en,
    input  rom_data,
    output issue_valid,
    input  issue_ready,
    output op, rd, rs, imm, we, alu_sel
  );

  modport slave (
    input  rom_addr, rom_en,
    output rom_data,
    input  issue_valid,
    output issue_ready,
    input  op, rd, rs, imm, we, alu_sel
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Three-cycle fetch/decode sequencer: reads one 25-bit word from a registered-output ROM,
// decodes it and offers it to the datapath with a valid/ready handshake.
module instr_fetch_decode #(
  parameter logic [2:0] START_PC = 3'd0,
  parameter int         WRAP     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  instr_fetch_decode_if.master        bus,
  output logic                        busy,
  output logic                        halted,
  output logic [2:0]                  pc,
  output logic [2:0]                  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [2:0] OP_HALT = 3'b111;

  state_t      state;
  logic [24:0] ir;
  logic        issue_valid;
  logic        we;
  logic [1:0]  alu_sel;
  logic        rom_en;

  logic [2:0]  rom_op;
  logic        dec_we;
  logic [1:0]  dec_alu;
  logic        last_addr;

  assign rom_op    = bus.rom_data[24:22];
  assign last_addr = (WRAP == 0) && (pc == 3'd7);

  // Decode straight from the ROM word so we/alu_sel are registered alongside IR.
  always_comb begin
    dec_we  = 1'b0;
    dec_alu = 2'b00;
    case (rom_op)
      3'b000:  begin dec_we = 1'b1; dec_alu = 2'b00; end
      3'b001:  begin dec_we = 1'b1; dec_alu = 2'b01; end
      3'b010:  begin dec_we = 1'b1; dec_alu = 2'b10; end
      3'b011:  begin dec_we = 1'b1; dec_alu = 2'b11; end
      default: begin dec_we = 1'b0; dec_alu = 2'b00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= START_PC;
      ir          <= '0;
      issue_valid <= 1'b0;
      we          <= 1'b0;
      alu_sel     <= 2'b00;
      busy        <= 1'b0;
      halted      <= 1'b0;
      rom_en      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state  <= S_FETCH;
            rom_en <= 1'b1;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          rom_en <= 1'b0;
          ir     <= bus.rom_data;
          // A halt word is consumed here: it advances pc but is never offered.
          if (rom_op == OP_HALT) begin
            state  <= S_HALT;
            pc     <= pc + 3'd1;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state       <= S_ISSUE;
            issue_valid <= 1'b1;
            we          <= dec_we;
            alu_sel     <= dec_alu;
          end
        end
        S_ISSUE: begin
          if (bus.issue_ready) begin
            issue_valid <= 1'b0;
            pc          <= pc + 3'd1;
            if (last_addr) begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              state  <= S_FETCH;
              rom_en <= 1'b1;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          issue_valid <= 1'b0;
          busy        <= 1'b0;
          halted      <= 1'b0;
          rom_en      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.rom_en      = rom_en;
  assign bus.issue_valid = issue_valid;
  assign bus.op          = ir[24:22];
  assign bus.rd          = ir[21:19];
  assign bus.rs          = ir[18:16];
  assign bus.imm         = ir[15:0];
  assign bus.we          = we;
  assign bus.alu_sel     = alu_sel;
  assign state_dbg       = state;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a WRAP=1 instance with a programmable ROM and a
// WRAP=0 instance fed an all-nop ROM; transfers are checked against an expected queue.
module tb_instr_fetch_decode;

  typedef struct {
    logic [2:0]  pc;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic        we;
    logic [1:0]  alu;
  } vec_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        busy0, halted0, busy1, halted1;
  logic [2:0]  pc0, pc1, st0, st1;
  logic [24:0] rom [8];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          xfers   = 0;
  int          last_xfer = 0;
  bit          tput_on = 1'b0;
  int          exp_pc1 = 0;
  logic [30:0] exp_q[$];
  vec_t        vecs[5];

  instr_fetch_decode_if b0 ();
  instr_fetch_decode_if b1 ();

  instr_fetch_decode #(.START_PC(3'd0), .WRAP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(b0.master),
    .busy(busy0), .halted(halted0), .pc(pc0), .state_dbg(st0)
  );

  instr_fetch_decode #(.START_PC(3'd0), .WRAP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(b1.master),
    .busy(busy1), .halted(halted1), .pc(pc1), .state_dbg(st1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ROM models: data appears one clock after the address
  always @(posedge clk) b0.rom_data <= rom[b0.rom_addr];
  always @(posedge clk) b1.rom_data <= {3'b100, 6'd0, 13'd0, b1.rom_addr};
  assign b1.issue_ready = 1'b1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] pack(input vec_t v);
    return {v.pc, v.op, v.rd, v.rs, v.imm, v.we, v.alu};
  endfunction

  function automatic logic [30:0] obs0();
    return {pc0, b0.op, b0.rd, b0.rs, b0.imm, b0.we, b0.alu_sel};
  endfunction

  function automatic logic [30:0] nop_exp(input logic [2:0] p);
    vec_t v;
    v = '{p, 3'b101, 3'd0, 3'd0, {13'd0, p}, 1'b0, 2'b00};
    return pack(v);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  // ---------------- scoreboard: every transfer must match the queue head ----------------
  always @(negedge clk) begin
    if (rst_n && b0.issue_valid && b0.issue_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_xfer: got transfer pc=%0d op=%0h, expected none", pc0, b0.op);
      end else begin
        n_tests--;
        check("xfer", {1'b0, obs0()}, {1'b0, exp_q.pop_front()});
      end
      if (tput_on && xfers > 0) check("throughput", cyc - last_xfer, 3);
      last_xfer = cyc;
      xfers++;
    end
    if (rst_n && b1.issue_valid) begin
      check("wrap0_pc", {29'd0, pc1}, exp_pc1[31:0] & 32'h7);
      exp_pc1++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{3'd0, 3'b000, 3'd2, 3'd0, 16'h0001, 1'b1, 2'b00};
    vecs[1] = '{3'd1, 3'b000, 3'd1, 3'd0, 16'h0001, 1'b1, 2'b00};
    vecs[2] = '{3'd2, 3'b010, 3'd2, 3'd1, 16'h0000, 1'b1, 2'b10};
    vecs[3] = '{3'd3, 3'b011, 3'd2, 3'd1, 16'h0000, 1'b1, 2'b11};
    vecs[4] = '{3'd4, 3'b001, 3'd7, 3'd1, 16'h0000, 1'b1, 2'b01};
    for (int i = 0; i < 8; i++) rom[i] = 25'h1C00000;

    // Reset with start and ready held high: reset must win.
    start0 = 1'b1;
    b0.issue_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_state", {29'd0, st0}, {29'd0, ST_IDLE});
    check("rst_pc", {29'd0, pc0}, 0);
    check("rst_ir", {7'd0, b0.op, b0.rd, b0.rs, b0.imm}, 0);
    check("rst_flags", {26'd0, b0.issue_valid, b0.we, b0.alu_sel, busy0, halted0},
          0);
    check("rst_rom", {28'd0, b0.rom_en, b0.rom_addr}, 0);
    @(posedge clk); #1 rst_n = 1'b1; start0 = 1'b0;

    // ---- program run: latency, ordering, throughput ----
    for (int i = 0; i < 5; i++) begin
      rom[i] = {vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm};
      exp_q.push_back(pack(vecs[i]));
    end
    rom[5] = 25'h1C00000;
    xfers = 0;
    tput_on = 1'b1;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    check("lat_fetch", {27'd0, st0, b0.rom_en, busy0}, {27'd0, ST_FETCH, 1'b1, 1'b1});
    check("lat_fetch_valid", {31'd0, b0.issue_valid}, 0);
    @(negedge clk);
    check("lat_wait", {28'd0, st0, b0.rom_en}, {28'd0, ST_WAIT, 1'b1});
    check("lat_wait_valid", {31'd0, b0.issue_valid}, 0);
    @(negedge clk);
    check("lat_issue", {27'd0, st0, b0.issue_valid, b0.rom_en}, {27'd0, ST_ISSUE, 2'b10});
    for (int i = 0; i < 40 && !halted0; i++) @(negedge clk);
    tput_on = 1'b0;
    check("prog_halted", {31'd0, halted0}, 1);
    check("prog_pc", {29'd0, pc0}, 6);
    check("prog_left", exp_q.size(), 0);
    check("prog_count", xfers, 5);

    // ---- back-pressure ----
    do_reset();
    b0.issue_ready = 1'b0;
    rom[0] = {3'b010, 3'd3, 3'd4, 16'h1234};
    rom[1] = 25'h1C00000;
    pulse_start();
    for (int i = 0; i < 10 && !b0.issue_valid; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'd0, b0.issue_valid}, 1);
      check("bp_fields", {1'b0, obs0()},
            {1'b0, 3'd0, 3'b010, 3'd3, 3'd4, 16'h1234, 1'b1, 2'b10});
      @(negedge clk);
    end
    @(posedge clk); #1 b0.issue_ready = 1'b1;
    exp_q.push_back({3'd0, 3'b010, 3'd3, 3'd4, 16'h1234, 1'b1, 2'b10});
    @(posedge clk); #1 b0.issue_ready = 1'b0;
    @(negedge clk);
    check("bp_left", exp_q.size(), 0);
    check("bp_pc", {29'd0, pc0}, 1);
    check("bp_after_valid", {31'd0, b0.issue_valid}, 0);

    // ---- halt word at address 3, then resume ----
    do_reset();
    b0.issue_ready = 1'b1;
    rom[0] = 25'h0;
    rom[1] = {3'b100, 3'd1, 3'd2, 16'hBEEF};
    rom[2] = {3'b110, 3'd7, 3'd7, 16'hFFFF};
    rom[3] = 25'h1C00000;
    rom[4] = {3'b000, 3'd5, 3'd0, 16'h00AA};
    rom[5] = 25'h1C00000;
    exp_q.push_back({3'd0, 3'b000, 3'd0, 3'd0, 16'h0000, 1'b1, 2'b00});
    exp_q.push_back({3'd1, 3'b100, 3'd1, 3'd2, 16'hBEEF, 1'b0, 2'b00});
    exp_q.push_back({3'd2, 3'b110, 3'd7, 3'd7, 16'hFFFF, 1'b0, 2'b00});
    pulse_start();
    for (int i = 0; i < 40 && !halted0; i++) @(negedge clk);
    check("halt_state", {28'd0, st0, halted0}, {28'd0, ST_HALT, 1'b1});
    check("halt_pc", {29'd0, pc0}, 4);
    check("halt_busy_romen", {30'd0, busy0, b0.rom_en}, 0);
    check("halt_left", exp_q.size(), 0);
    exp_q.push_back({3'd4, 3'b000, 3'd5, 3'd0, 16'h00AA, 1'b1, 2'b00});
    pulse_start();
    @(negedge clk);
    check("resume_addr", {28'd0, b0.rom_en, b0.rom_addr}, {28'd0, 1'b1, 3'd4});
    for (int i = 0; i < 40 && !halted0; i++) @(negedge clk);
    check("resume_pc", {29'd0, pc0}, 6);
    check("resume_left", exp_q.size(), 0);

    // ---- wrap: WRAP=1 runs 0..7,0; WRAP=0 halts after 7 with pc=0 ----
    do_reset();
    for (int i = 0; i < 8; i++) rom[i] = {3'b101, 6'd0, 13'd0, 3'(i)};
    for (int k = 0; k < 9; k++) exp_q.push_back(nop_exp(3'(k % 8)));
    exp_pc1 = 0;
    @(posedge clk); #1 start0 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
    check("wrap1_left", exp_q.size(), 0);
    check("wrap0_halted", {31'd0, halted1}, 1);
    check("wrap0_pc_end", {29'd0, pc1}, 0);
    check("wrap0_count", exp_pc1, 8);

    // ---- reset while an instruction is held at pc=2 ----
    do_reset();
    b0.issue_ready = 1'b1;
    exp_q.push_back(nop_exp(3'd0));
    exp_q.push_back(nop_exp(3'd1));
    pulse_start();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1 b0.issue_ready = 1'b0;
    for (int i = 0; i < 20 && !(b0.issue_valid && pc0 == 3'd2); i++) @(negedge clk);
    check("mid_issue_pc", {29'd0, pc0}, 2);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_pre_reset_valid", {31'd0, b0.issue_valid}, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_post_valid", {31'd0, b0.issue_valid}, 0);
    check("mid_post_pc", {29'd0, pc0}, 0);
    check("mid_post_state", {29'd0, st0}, {29'd0, ST_IDLE});
    check("mid_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
